// File: rtl/alu_instr_encoder_if.sv
// Request/response bundle for alu_instr_encoder: encode request in, instruction word stream out.
// master = request producer / word consumer, slave = encoder.
interface alu_instr_encoder_if;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  in_alu_op;
   logic        in_is_imm;
   logic [4:0]  in_rd;
   logic [4:0]  in_rs1;
   logic [4:0]  in_rs2;
   logic [11:0] in_imm;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;

   modport master (
      output in_valid, in_alu_op, in_is_imm, in_rd, in_rs1, in_rs2, in_imm, out_ready,
      input  in_ready, out_valid, out_instr
   );

   modport slave (
      input  in_valid, in_alu_op, in_is_imm, in_rd, in_rs1, in_rs2, in_imm, out_ready,
      output in_ready, out_valid, out_instr
   );
endinterface

// File: rtl/alu_instr_encoder.sv
// Assembles RV32I R/I-type ALU instructions from alu_control codes into a small output FIFO.
// Optional encoded-word counter enabled by defining ENC_COUNT_EN.
module alu_instr_encoder #(
   parameter int unsigned DEPTH   = 2,
   parameter int unsigned COUNT_W = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   alu_instr_encoder_if.slave   bus,
   output logic                 err_illegal,
   output logic [3:0]           err_alu_op,
   output logic [COUNT_W-1:0]   enc_count
);

   localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CntW = PtrW + 1;

   typedef enum logic [3:0] {
      OpAnd  = 4'b0000,
      OpOr   = 4'b0001,
      OpAdd  = 4'b0010,
      OpSll  = 4'b0011,
      OpSub  = 4'b0100,
      OpSrl  = 4'b0101,
      OpSltu = 4'b0110,
      OpXor  = 4'b0111,
      OpSlt  = 4'b1000,
      OpSra  = 4'b1001
   } alu_op_e;

   localparam logic [6:0] OpcodeR = 7'b0110011;
   localparam logic [6:0] OpcodeI = 7'b0010011;
   localparam logic [6:0] Funct7Alt = 7'b0100000;

   // ---------------------------------------------------------------------------------------------
   // Combinational encoder
   // ---------------------------------------------------------------------------------------------
   logic [2:0]  funct3;
   logic [6:0]  funct7;
   logic        is_shift;
   logic        illegal;
   logic [11:0] imm_field;
   logic [31:0] instr;

   always_comb begin
      funct3   = 3'b000;
      funct7   = 7'b0000000;
      is_shift = 1'b0;
      illegal  = 1'b0;
      case (alu_op_e'(bus.in_alu_op))
         OpAnd:  funct3 = 3'b111;
         OpOr:   funct3 = 3'b110;
         OpAdd:  funct3 = 3'b000;
         OpSll: begin
            funct3   = 3'b001;
            is_shift = 1'b1;
         end
         OpSub: begin
            funct3  = 3'b000;
            funct7  = Funct7Alt;
            // No SUBI in RV32I.
            illegal = bus.in_is_imm;
         end
         OpSrl: begin
            funct3   = 3'b101;
            is_shift = 1'b1;
         end
         OpSltu: funct3 = 3'b011;
         OpXor:  funct3 = 3'b100;
         OpSlt:  funct3 = 3'b010;
         OpSra: begin
            funct3   = 3'b101;
            funct7   = Funct7Alt;
            is_shift = 1'b1;
         end
         default: illegal = 1'b1;
      endcase

      // Immediate shifts carry funct7 in imm[11:5] and only a 5-bit shamt.
      imm_field = is_shift ? {funct7, bus.in_imm[4:0]} : bus.in_imm;

      if (bus.in_is_imm) begin
         instr = {imm_field, bus.in_rs1, funct3, bus.in_rd, OpcodeI};
      end else begin
         instr = {funct7, bus.in_rs2, bus.in_rs1, funct3, bus.in_rd, OpcodeR};
      end
   end

   // ---------------------------------------------------------------------------------------------
   // Output FIFO
   // ---------------------------------------------------------------------------------------------
   logic [31:0]     mem_q [DEPTH];
   logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0] count_q, count_d;
   logic            accept;
   logic            push;
   logic            pop;

   // No full-pop bypass: readiness depends on registered occupancy only.
   assign bus.in_ready  = rst_n && (count_q < CntW'(DEPTH));
   assign bus.out_valid = (count_q != '0);
   assign bus.out_instr = bus.out_valid ? mem_q[rd_ptr_q] : 32'h0;

   assign accept = bus.in_valid && bus.in_ready;
   assign push   = accept && !illegal;
   assign pop    = bus.out_valid && bus.out_ready;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         wr_ptr_d = wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      case ({push, pop})
         2'b10:   count_d = count_q + CntW'(1);
         2'b01:   count_d = count_q - CntW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset; empty entries are masked at the output.
   always_ff @(posedge clk) begin
      if (rst_n && push) begin
         mem_q[wr_ptr_q] <= instr;
      end
   end

   // ---------------------------------------------------------------------------------------------
   // Sticky illegal-request capture
   // ---------------------------------------------------------------------------------------------
   logic       err_illegal_q, err_illegal_d;
   logic [3:0] err_alu_op_q, err_alu_op_d;

   always_comb begin
      err_illegal_d = err_illegal_q;
      err_alu_op_d  = err_alu_op_q;
      if (accept && illegal) begin
         err_illegal_d = 1'b1;
         if (!err_illegal_q) begin
            err_alu_op_d = bus.in_alu_op;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         err_illegal_q <= 1'b0;
         err_alu_op_q  <= 4'h0;
      end else begin
         err_illegal_q <= err_illegal_d;
         err_alu_op_q  <= err_alu_op_d;
      end
   end

   assign err_illegal = err_illegal_q;
   assign err_alu_op  = err_alu_op_q;

   // ---------------------------------------------------------------------------------------------
   // Encoded-word counter
   // ---------------------------------------------------------------------------------------------
`ifdef ENC_COUNT_EN
   logic [COUNT_W-1:0] enc_count_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         enc_count_q <= '0;
      end else if (push) begin
         enc_count_q <= enc_count_q + COUNT_W'(1);
      end
   end

   assign enc_count = enc_count_q;
`else
   assign enc_count = '0;
`endif

endmodule

// File: tb/tb_alu_instr_encoder.sv
// Directed, table-driven bench for alu_instr_encoder (DEPTH=2), plus illegal-request,
// backpressure and mid-drain reset sequences.
module tb_alu_instr_encoder;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        err_illegal;
   logic [3:0]  err_alu_op;
   logic [15:0] enc_count;

   int n_checks = 0;
   int n_fail   = 0;
   int model_cnt = 0;

`ifdef ENC_COUNT_EN
   localparam bit CntEn = 1'b1;
`else
   localparam bit CntEn = 1'b0;
`endif

   always #5 clk = ~clk;

   alu_instr_encoder_if bus ();

   alu_instr_encoder #(
      .DEPTH  (2),
      .COUNT_W(16)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .bus        (bus),
      .err_illegal(err_illegal),
      .err_alu_op (err_alu_op),
      .enc_count  (enc_count)
   );

   typedef struct {
      logic [3:0]  op;
      logic        is_imm;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [11:0] imm;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs[12];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] exp_count();
      return CntEn ? 32'(model_cnt) : 32'h0;
   endfunction

   task automatic drive_req(input logic [3:0] op, input logic is_imm, input logic [4:0] rd,
                            input logic [4:0] rs1, input logic [4:0] rs2,
                            input logic [11:0] imm);
      bus.in_valid  = 1'b1;
      bus.in_alu_op = op;
      bus.in_is_imm = is_imm;
      bus.in_rd     = rd;
      bus.in_rs1    = rs1;
      bus.in_rs2    = rs2;
      bus.in_imm    = imm;
   endtask

   // Present a request, wait (bounded) for in_ready, complete the handshake.
   task automatic send(input logic [3:0] op, input logic is_imm, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [11:0] imm);
      int k = 0;
      drive_req(op, is_imm, rd, rs1, rs2, imm);
      while (!bus.in_ready && k < 20) begin
         @(negedge clk);
         k++;
      end
      check("send in_ready", 32'(bus.in_ready), 32'h1);
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1 rst_n = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      model_cnt = 0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vecs[0]  = '{4'h2, 1'b0, 5'd3,  5'd1,  5'd2,  12'h000, 32'h002081B3}; // add
      vecs[1]  = '{4'h4, 1'b0, 5'd5,  5'd6,  5'd7,  12'h000, 32'h407302B3}; // sub
      vecs[2]  = '{4'h9, 1'b1, 5'd1,  5'd2,  5'd9,  12'h0E3, 32'h40315093}; // srai
      vecs[3]  = '{4'h2, 1'b1, 5'd1,  5'd0,  5'd0,  12'hFFF, 32'hFFF00093}; // addi -1
      vecs[4]  = '{4'h0, 1'b0, 5'd10, 5'd11, 5'd12, 12'h000, 32'h00C5F533}; // and
      vecs[5]  = '{4'h7, 1'b1, 5'd4,  5'd5,  5'd0,  12'h0F0, 32'h0F02C213}; // xori
      vecs[6]  = '{4'h3, 1'b1, 5'd7,  5'd8,  5'd0,  12'hFFF, 32'h01F41393}; // slli 31
      vecs[7]  = '{4'h9, 1'b0, 5'd1,  5'd2,  5'd3,  12'h000, 32'h403150B3}; // sra
      vecs[8]  = '{4'h6, 1'b0, 5'd31, 5'd30, 5'd29, 12'h000, 32'h01DF3FB3}; // sltu
      vecs[9]  = '{4'h8, 1'b1, 5'd2,  5'd3,  5'd0,  12'h800, 32'h8001A113}; // slti -2048
      vecs[10] = '{4'h1, 1'b1, 5'd9,  5'd9,  5'd0,  12'h123, 32'h1234E493}; // ori
      vecs[11] = '{4'h5, 1'b1, 5'd1,  5'd1,  5'd0,  12'hFE5, 32'h0050D093}; // srli

      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_alu_op = 4'h0;
      bus.in_is_imm = 1'b0;
      bus.in_rd     = 5'd0;
      bus.in_rs1    = 5'd0;
      bus.in_rs2    = 5'd0;
      bus.in_imm    = 12'h0;
      bus.out_ready = 1'b1;

      // Reset state.
      @(posedge clk);
      @(negedge clk);
      check("reset in_ready", 32'(bus.in_ready), 32'h0);
      check("reset out_valid", 32'(bus.out_valid), 32'h0);
      check("reset out_instr", bus.out_instr, 32'h0);
      check("reset err_illegal", 32'(err_illegal), 32'h0);
      check("reset err_alu_op", 32'(err_alu_op), 32'h0);
      check("reset enc_count", 32'(enc_count), 32'h0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check("post-reset in_ready", 32'(bus.in_ready), 32'h1);

      // Table: each word visible exactly one cycle after acceptance.
      for (int i = 0; i < 12; i++) begin
         send(vecs[i].op, vecs[i].is_imm, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].imm);
         model_cnt++;
         @(negedge clk);
         check($sformatf("vec%0d out_valid", i), 32'(bus.out_valid), 32'h1);
         check($sformatf("vec%0d out_instr", i), bus.out_instr, vecs[i].exp);
         check($sformatf("vec%0d enc_count", i), 32'(enc_count), exp_count());
      end
      @(negedge clk);
      check("drained out_valid", 32'(bus.out_valid), 32'h0);

      // Illegal requests: accepted, not pushed, first op captured.
      send(4'h4, 1'b1, 5'd1, 5'd2, 5'd3, 12'h001);
      @(negedge clk);
      check("subi out_valid", 32'(bus.out_valid), 32'h0);
      check("subi err_illegal", 32'(err_illegal), 32'h1);
      check("subi err_alu_op", 32'(err_alu_op), 32'h4);
      send(4'hF, 1'b0, 5'd1, 5'd2, 5'd3, 12'h000);
      @(negedge clk);
      check("op15 out_valid", 32'(bus.out_valid), 32'h0);
      check("op15 err_illegal", 32'(err_illegal), 32'h1);
      check("op15 err_alu_op", 32'(err_alu_op), 32'h4);
      check("op15 enc_count", 32'(enc_count), exp_count());
      send(4'h2, 1'b0, 5'd3, 5'd1, 5'd2, 12'h000);
      model_cnt++;
      @(negedge clk);
      check("legal after illegal", bus.out_instr, 32'h002081B3);
      check("legal after illegal cnt", 32'(enc_count), exp_count());

      do_reset();
      @(negedge clk);
      check("reset clears err", 32'(err_illegal), 32'h0);
      check("reset clears err_op", 32'(err_alu_op), 32'h0);

      // Backpressure: fill DEPTH=2, third request stalls, drain in order.
      bus.out_ready = 1'b0;
      @(posedge clk);
      #1 drive_req(4'h2, 1'b0, 5'd3, 5'd1, 5'd2, 12'h000);
      @(negedge clk);
      check("bp A in_ready", 32'(bus.in_ready), 32'h1);
      @(posedge clk);
      #1 drive_req(4'h4, 1'b0, 5'd5, 5'd6, 5'd7, 12'h000);
      @(negedge clk);
      check("bp B in_ready", 32'(bus.in_ready), 32'h1);
      check("bp head A", bus.out_instr, 32'h002081B3);
      @(posedge clk);
      #1 drive_req(4'h9, 1'b1, 5'd1, 5'd2, 5'd0, 12'h0E3);
      model_cnt = 2;
      @(negedge clk);
      check("bp full in_ready", 32'(bus.in_ready), 32'h0);
      check("bp full count", 32'(enc_count), exp_count());
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         check("bp hold in_ready", 32'(bus.in_ready), 32'h0);
         check("bp hold head", bus.out_instr, 32'h002081B3);
      end
      @(posedge clk);
      #1 bus.out_ready = 1'b1;
      @(negedge clk);
      check("bp no bypass", 32'(bus.in_ready), 32'h0);
      @(posedge clk);
      @(negedge clk);
      check("bp head B", bus.out_instr, 32'h407302B3);
      check("bp C ready", 32'(bus.in_ready), 32'h1);
      @(posedge clk);
      #1;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      model_cnt = 3;
      @(negedge clk);
      check("bp head C valid", 32'(bus.out_valid), 32'h1);
      check("bp head C", bus.out_instr, 32'h40315093);
      check("bp count 3", 32'(enc_count), exp_count());

      // Reset with a word still buffered.
      @(posedge clk);
      #1 rst_n = 1'b0;
      @(negedge clk);
      check("mid rst in_ready", 32'(bus.in_ready), 32'h0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      model_cnt = 0;
      @(negedge clk);
      check("mid rst out_valid", 32'(bus.out_valid), 32'h0);
      check("mid rst out_instr", bus.out_instr, 32'h0);
      check("mid rst enc_count", 32'(enc_count), exp_count());

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_instr_encoder.md
Name: alu_instr_encoder

Overview:
- Inverse of the control decoder. Takes an ALU operation code (same 4-bit alu_control encoding), register indices and an immediate, and assembles a legal RV32I R-type or I-type instruction word.
- Encoded words are buffered in a small FIFO with valid/ready on both sides.
- Used by the self-test program generator and the bench stimulus path to feed instruction memory and the decoder.

Parameters:
- DEPTH, 2, output FIFO entries; power of 2, ≥2.
- COUNT_W, 16, width of the encoded-instruction counter (only used with ENC_COUNT_EN).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted when in_valid && in_ready.
- in_alu_op  in  4  alu_control code: 0000 AND, 0001 OR, 0010 ADD, 0011 SLL, 0100 SUB, 0101 SRL, 0110 SLTU, 0111 XOR, 1000 SLT, 1001 SRA.
- in_is_imm  in  1  1 = I-type (opcode 0010011); 0 = R-type (opcode 0110011).
- in_rd, in_rs1, in_rs2  in  5 each  register indices; in_rs2 is ignored for I-type.
- in_imm  in  12  immediate; for shifts only in_imm[4:0] (shamt) is used.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  consumer pops head when out_valid && out_ready.
- out_instr  out  32  FIFO head instruction word.
- err_illegal  out  1  sticky illegal-request flag.
- err_alu_op  out  4  alu_op of the first illegal request.
- enc_count  out  COUNT_W  number of words pushed into the FIFO.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - FIFO flushed; out_valid=0; out_instr=0.
  - err_illegal=0; err_alu_op=0; enc_count=0.
  - in_ready=0 during the reset cycle.
  - Reset mid-stream discards all buffered words.
- in_ready = (fifo occupancy < DEPTH). It is registered-state based with no full-pop bypass: when full, in_ready=0 even if a pop occurs in the same cycle.
- Encoding is combinational on an accepted request. The word is written at the same edge and is visible at out_instr/out_valid from the next cycle, so latency is 1 cycle when the FIFO is empty.
- R-type fields: [31:25] funct7, [24:20] rs2, [19:15] rs1, [14:12] funct3, [11:7] rd, [6:0] 0110011.
- I-type fields: [31:20] imm, [19:15] rs1, [14:12] funct3, [11:7] rd, [6:0] 0010011.
- funct3 by op: ADD/SUB 000, SLL 001, SLT 010, SLTU 011, XOR 100, SRL/SRA 101, OR 110, AND 111.
- funct7 (R-type) is 0100000 for SUB and SRA, else 0000000.
- I-type shifts: imm[11:5] is forced to 0100000 for SRA and 0000000 for SLL/SRL; imm[4:0] = in_imm[4:0].
- Illegal requests: in_alu_op ∈ {1010..1111}, or SUB with in_is_imm=1.
  - Still accepted (handshake completes) but not pushed; enc_count unchanged.
  - err_illegal set to 1 and held until reset.
  - err_alu_op is captured only when err_illegal was 0.
- Simultaneous push and pop: occupancy unchanged and FIFO order preserved.
- Read/write pointers wrap modulo DEPTH.
- out_instr holds its value while out_valid && !out_ready.
- Pop when empty has no effect.

Optional Feature:
- ENC_COUNT_EN defined: enc_count increments by 1 on every legal push and wraps from 2^COUNT_W−1 to 0.
- Not defined: no counter register; enc_count is tied to 0.

Test Plan:
- ADD x3,x1,x2 (op 0010, imm 0, rd 3, rs1 1, rs2 2), out_ready=1 -> out_instr=0x002081B3 one cycle after accept; enc_count=1.
- SUB x5,x6,x7 (op 0100, R-type) -> 0x407302B3.
- SRAI x1,x2,3 (op 1001, I-type, in_imm=0x0E3) -> 0x40315093, upper imm bits forced.
- ADDI x1,x0,-1 (op 0010, I-type, in_imm=0xFFF) -> 0xFFF00093.
- op 0100 with in_is_imm=1, then op 1111 -> no out_valid; err_illegal=1; err_alu_op=0100; enc_count unchanged.
- out_ready=0, 3 back-to-back legal requests with DEPTH=2 -> in_ready=0 after 2; release out_ready -> words emerge in order, third accepted; assert rst_n=0 mid-drain -> out_valid=0 next cycle.
